// File: rtl/shake_job_arbiter.sv
// shake_job_arbiter: round-robin, job-granular sharing of one SHAKE core between NUM_REQ requesters.
// Optional watchdog abort enabled by defining SHAKE_ARB_WATCHDOG_EN.
module shake_job_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_grant,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_data_valid,
   input  logic [NUM_REQ-1:0]          req_data_last,
   output logic [NUM_REQ-1:0]          req_data_ready,
   output logic                        core_start,
   output logic [DATA_W-1:0]           core_data,
   output logic                        core_data_valid,
   output logic                        core_data_last,
   input  logic                        core_data_ready,
   input  logic [DATA_W-1:0]           core_out_data,
   input  logic                        core_out_valid,
   input  logic                        core_out_last,
   output logic                        core_out_ready,
   output logic [DATA_W-1:0]           rsp_data,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic                        rsp_last,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]  owner_id,
`ifdef SHAKE_ARB_WATCHDOG_EN
   output logic                        core_abort,
   output logic [NUM_REQ-1:0]          timeout_flag,
`endif
   output logic                        busy
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;
   state_t state, state_nx;
   logic [IW-1:0] rr_ptr, rr_nx, owner_nx, win, idx;
   logic [NUM_REQ-1:0] one_hot;
   logic act, job_end, done;
   assign act        = state == ACTIVE;
   assign busy       = state != IDLE;
   assign core_start = state == START;
   assign one_hot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_id;
   assign req_grant  = busy ? one_hot : '0;
   // Data and last pass straight through; only the handshake bits are gated by ownership.
   assign core_data       = req_data[int'(owner_id)*DATA_W +: DATA_W];
   assign core_data_valid = act & req_data_valid[owner_id];
   assign core_data_last  = req_data_last[owner_id];
   assign req_data_ready  = (act & core_data_ready) ? one_hot : '0;
   assign core_out_ready  = act & rsp_ready[owner_id];
   assign rsp_valid       = (act & core_out_valid) ? one_hot : '0;
   assign rsp_data        = core_out_data;
   assign rsp_last        = core_out_last;
   assign job_end         = core_out_valid & core_out_ready & core_out_last;
   // Scan downward so the lowest offset from rr_ptr wins.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
         if (req_valid[idx]) win = idx;
      end
   end
   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      owner_nx = owner_id;
      if (state == IDLE && |req_valid) begin
         state_nx = START;
         owner_nx = win;
      end
      if (state == START) state_nx = ACTIVE;
      if (done) begin
         state_nx = IDLE;
         owner_nx = '0;
         rr_nx    = (owner_id == IW'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      state    <= rst ? IDLE : state_nx;
      rr_ptr   <= rst ? '0 : rr_nx;
      owner_id <= rst ? '0 : owner_nx;
   end
`ifdef SHAKE_ARB_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_cnt;
   logic hs;
   assign hs         = (core_data_valid & core_data_ready) | (core_out_valid & core_out_ready);
   assign core_abort = act & ~hs & (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
   assign done       = job_end | core_abort;
   always_ff @(posedge clk) begin
      wd_cnt       <= (rst || !act || hs) ? '0 : wd_cnt + 1'b1;
      timeout_flag <= rst ? '0 : (core_abort ? timeout_flag | one_hot : timeout_flag);
   end
`else
   assign done = job_end;
`endif
endmodule

// File: tb/tb_shake_job_arbiter.sv
// tb_shake_job_arbiter: vector table, directed corner sequences and randomized traffic vs a job-level model.
module tb_shake_job_arbiter;
   localparam int N = 4;
   localparam int W = 16;
   localparam int TO = 16;
`ifdef SHAKE_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif
   logic clk = 1'b0, rst;
   logic [N-1:0] req_valid, req_grant, req_data_valid, req_data_last, req_data_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_data;
   logic core_start, core_data_valid, core_data_last, core_data_ready, core_out_valid, core_out_last, core_out_ready, rsp_last, busy;
   logic [W-1:0] core_data, core_out_data, rsp_data;
   logic [1:0] owner_id;
`ifdef SHAKE_ARB_WATCHDOG_EN
   logic core_abort;
   logic [N-1:0] timeout_flag;
`endif
   int errors = 0, checks = 0, cyc = 0;
   int m_owner, m_age, m_next, m_quiet;
   logic [N-1:0] m_tflag;

   shake_job_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_grant(req_grant), .req_data(req_data),
      .req_data_valid(req_data_valid), .req_data_last(req_data_last), .req_data_ready(req_data_ready),
      .core_start(core_start), .core_data(core_data), .core_data_valid(core_data_valid),
      .core_data_last(core_data_last), .core_data_ready(core_data_ready), .core_out_data(core_out_data),
      .core_out_valid(core_out_valid), .core_out_last(core_out_last), .core_out_ready(core_out_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
      .owner_id(owner_id),
`ifdef SHAKE_ARB_WATCHDOG_EN
      .core_abort(core_abort), .timeout_flag(timeout_flag),
`endif
      .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] rv, dv, dl;
      logic cdr, cov, col;
      logic [3:0] rsr, grant;
      logic [1:0] oid;
      logic start, bsy;
      logic [3:0] rdy, rspv;
      logic cor, cdv;
   } vec_t;
   vec_t tbl[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_data_valid = '0; req_data_last = '0; rsp_ready = '0;
      req_data = {16'hD3, 16'hD2, 16'hD1, 16'hD0};
      core_data_ready = 0; core_out_valid = 0; core_out_last = 0; core_out_data = 16'hBEEF;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   // Job-level reference model: owner (-1 = none), cycles since grant, next search start.
   function automatic logic [1:0] m_ob();
      return m_owner >= 0 ? 2'(m_owner) : 2'd0;
   endfunction
   function automatic logic m_active();
      return m_owner >= 0 && m_age > 0;
   endfunction
   function automatic logic m_hs();
      return m_active() && ((req_data_valid[m_ob()] && core_data_ready) || (core_out_valid && rsp_ready[m_ob()]));
   endfunction
   function automatic logic m_abort();
      return WD && m_active() && !m_hs() && m_quiet == TO - 1;
   endfunction

   function automatic logic [63:0] m_exp();
      logic b, p;
      logic [3:0] oh;
      logic [1:0] o;
      b = m_owner >= 0; o = m_ob(); p = m_active();
      oh = b ? 4'(1 << o) : 4'b0;
      m_exp = 64'({oh, o, b, b && m_age == 0, p && req_data_valid[o], req_data_last[o],
                   (p && core_data_ready) ? oh : 4'b0, p && rsp_ready[o], (p && core_out_valid) ? oh : 4'b0,
                   core_out_last, req_data[int'(o)*W +: W], core_out_data});
`ifdef SHAKE_ARB_WATCHDOG_EN
      m_exp = {m_exp[62:0], m_abort()};
`endif
   endfunction

   function automatic logic [63:0] pack_act();
      pack_act = 64'({req_grant, owner_id, busy, core_start, core_data_valid, core_data_last, req_data_ready,
                      core_out_ready, rsp_valid, rsp_last, core_data, rsp_data});
`ifdef SHAKE_ARB_WATCHDOG_EN
      pack_act = {pack_act[62:0], core_abort};
`endif
   endfunction

   task automatic model_clock();
      logic fin;
      if (rst) begin
         m_owner = -1; m_age = 0; m_next = 0; m_quiet = 0; m_tflag = '0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++)
            if (req_valid[2'((m_next + k) % N)]) begin
               m_owner = (m_next + k) % N; m_age = 0; m_quiet = 0;
               break;
            end
      end else if (m_age == 0) m_age = 1;
      else begin
         fin = core_out_valid && rsp_ready[m_ob()] && core_out_last;
         if (m_abort()) begin
            m_tflag[m_ob()] = 1'b1;
            fin = 1'b1;
         end
         if (fin) begin
            m_next = (m_owner + 1) % N;
            m_owner = -1;
         end else m_quiet = m_hs() ? 0 : m_quiet + 1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, prev;
      tbl[0]  = '{4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 4'b0000, 4'b0000, 0, 0};
      tbl[1]  = '{4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 4'b0100, 2'd2, 1, 1, 4'b0000, 4'b0000, 0, 0};
      tbl[2]  = '{4'b0000, 4'b0101, 4'b0000, 1, 0, 0, 4'b0000, 4'b0100, 2'd2, 0, 1, 4'b0100, 4'b0000, 0, 1};
      tbl[3]  = '{4'b0000, 4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 4'b0100, 2'd2, 0, 1, 4'b0100, 4'b0000, 0, 1};
      tbl[4]  = '{4'b0000, 4'b0100, 4'b0100, 1, 1, 0, 4'b0100, 4'b0100, 2'd2, 0, 1, 4'b0100, 4'b0100, 1, 1};
      tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b1011, 4'b0100, 2'd2, 0, 1, 4'b0000, 4'b0100, 0, 0};
      tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b0100, 4'b0100, 2'd2, 0, 1, 4'b0000, 4'b0100, 1, 0};
      tbl[7]  = '{4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 4'b0000, 4'b0000, 0, 0};
      tbl[8]  = '{4'b0101, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0001, 2'd0, 1, 1, 4'b0000, 4'b0000, 0, 0};
      tbl[9]  = '{4'b0000, 4'b0001, 4'b0001, 1, 1, 1, 4'b1111, 4'b0001, 2'd0, 0, 1, 4'b0001, 4'b0001, 1, 1};
      tbl[10] = '{4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 4'b0000, 4'b0000, 0, 0};
      tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 2'd2, 1, 1, 4'b0000, 4'b0000, 0, 0};
      tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 2'd2, 0, 1, 4'b0000, 4'b0000, 0, 0};
      do_reset();
      @(negedge clk);
      chk("reset", 64'({req_grant, owner_id, busy, core_start, req_data_ready, rsp_valid, core_out_ready, core_data_valid}), 64'd0);
      tick();
      for (int r = 0; r < 13; r++) begin
         req_valid = tbl[r].rv; req_data_valid = tbl[r].dv; req_data_last = tbl[r].dl;
         core_data_ready = tbl[r].cdr; core_out_valid = tbl[r].cov; core_out_last = tbl[r].col; rsp_ready = tbl[r].rsr;
         @(negedge clk);
         chk($sformatf("tbl%0d_ctl", r), 64'({req_grant, owner_id, core_start, busy}),
             64'({tbl[r].grant, tbl[r].oid, tbl[r].start, tbl[r].bsy}));
         chk($sformatf("tbl%0d_hs", r), 64'({req_data_ready, rsp_valid, core_out_ready, core_data_valid}),
             64'({tbl[r].rdy, tbl[r].rspv, tbl[r].cor, tbl[r].cdv}));
         if (tbl[r].bsy) chk($sformatf("tbl%0d_data", r), 64'(core_data), 64'(16'hD0 + 16'(tbl[r].oid)));
         tick();
      end
      // Round robin with all requesters held and every job ending in its first active cycle.
      do_reset();
      req_valid = 4'b1111; core_out_valid = 1; core_out_last = 1; rsp_ready = 4'b1111;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         t = 0;
         @(negedge clk);
         while (!core_start && t < 10) begin
            tick();
            @(negedge clk);
            t++;
         end
         chk($sformatf("rr%0d_start", k), 64'(core_start), 64'd1);
         chk($sformatf("rr%0d_owner", k), 64'(owner_id), 64'(k % N));
         if (k > 0) chk($sformatf("rr%0d_gap", k), 64'(cyc - prev), 64'd3);
         prev = cyc;
         tick();
      end
      // Isolation and backpressure: requester 1 owns, requester 3 pushes, owner withholds rsp_ready.
      do_reset();
      req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      req_valid = 4'b0010;
      tick();
      tick();
      req_valid = 4'b1000; req_data_valid = 4'b1010; core_data_ready = 1;
      core_out_valid = 1; core_out_last = 1; rsp_ready = 4'b1000;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("iso_rdy", 64'(req_data_ready), 64'(4'b0010));
         chk("iso_rsp", 64'(rsp_valid), 64'(4'b0010));
         chk("iso_data", 64'(core_data), 64'(16'h1111));
         chk("bp_hold", 64'({core_out_ready, req_grant}), 64'({1'b0, 4'b0010}));
         tick();
      end
      rsp_ready = 4'b1010;
      @(negedge clk);
      chk("bp_release", 64'(core_out_ready), 64'd1);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("bp_end", 64'({req_grant, busy}), 64'd0);
      // Reset mid-job with rr_ptr previously advanced to 1.
      do_reset();
      req_valid = 4'b0001;
      tick();
      tick();
      req_valid = '0; core_out_valid = 1; core_out_last = 1; rsp_ready = 4'b0001;
      tick();
      idle_inputs();
      req_valid = 4'b0100;
      tick();
      tick();
      req_valid = '0; core_out_valid = 1; rsp_ready = 4'b0100; req_data_valid = 4'b0100; core_data_ready = 1;
      @(negedge clk);
      chk("rst_pre", 64'({busy, owner_id, rsp_valid}), 64'({1'b1, 2'd2, 4'b0100}));
      tick();
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      chk("rst_outs", 64'({req_grant, owner_id, busy, core_start, req_data_ready, rsp_valid, core_out_ready, core_data_valid}), 64'd0);
      idle_inputs();
      req_valid = 4'b0011;
      tick();
      @(negedge clk);
      chk("rst_regrant", 64'({req_grant, owner_id, core_start}), 64'({4'b0001, 2'd0, 1'b1}));
`ifdef SHAKE_ARB_WATCHDOG_EN
      do_reset();
      req_valid = 4'b1100;
      tick();
      tick();
      t = 1;
      @(negedge clk);
      while (!core_abort && t < 40) begin
         tick();
         @(negedge clk);
         t++;
      end
      chk("wd_cycles", 64'(t), 64'(TO));
      chk("wd_abort", 64'(core_abort), 64'd1);
      tick();
      @(negedge clk);
      chk("wd_flag", 64'({timeout_flag, busy}), 64'({4'b0100, 1'b0}));
      tick();
      @(negedge clk);
      chk("wd_next", 64'({req_grant, core_start}), 64'({4'b1000, 1'b1}));
`endif
      // Randomized traffic against the job-level model.
      do_reset();
      m_owner = -1; m_age = 0; m_next = 0; m_quiet = 0; m_tflag = '0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom % 300) == 0;
         req_valid = 4'($urandom); req_data = {$urandom, $urandom};
         req_data_valid = 4'($urandom); req_data_last = 4'($urandom); core_data_ready = 1'($urandom);
         core_out_data = 16'($urandom); core_out_valid = 1'($urandom); core_out_last = ($urandom % 4) == 0;
         rsp_ready = 4'($urandom);
         @(negedge clk);
         chk("rand", pack_act(), m_exp());
`ifdef SHAKE_ARB_WATCHDOG_EN
         chk("rand_tflag", 64'(timeout_flag), 64'(m_tflag));
`endif
         @(posedge clk);
         model_clock();
         #1;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
